// File: rtl/bas_pkg.sv
// Shared types and constants for the bas restart controller.
package bas_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCrst,
        StCload,
        StRun,
        StCapt,
        StFin
    } state_e;

    localparam int unsigned Q88_W   = 16;
    localparam int unsigned VALUE_W = 40;
    localparam int unsigned SEED_W  = 9;
    localparam int unsigned ITER_W  = 9;

    // Core reports this when it has no valid result (e.g. zero iterations).
    localparam logic [VALUE_W-1:0] CORE_SENTINEL = 40'h0FFFFFFFFF;
    // Most positive signed value; any real result beats it.
    localparam logic [VALUE_W-1:0] BEST_INIT     = 40'h7FFFFFFFFF;

    // An all-zero LFSR seed locks up, so substitute 1.
    function automatic logic [SEED_W-1:0] fix_seed(input logic [SEED_W-1:0] s);
        return (s == '0) ? SEED_W'(1) : s;
    endfunction

endpackage

// File: rtl/bas_seed_gen.sv
// Per-run seed generator: offsets the base seeds by run * SEED_STRIDE (x up, y down).
module bas_seed_gen
    import bas_pkg::*;
#(
    parameter int unsigned       RUNS_W      = 8,
    parameter logic [SEED_W-1:0] SEED_STRIDE = 9'd37
) (
    input  logic [RUNS_W-1:0] i_run,
    input  logic [SEED_W-1:0] i_seed_x,
    input  logic [SEED_W-1:0] i_seed_y,
    output logic [SEED_W-1:0] o_seed_x,
    output logic [SEED_W-1:0] o_seed_y
);

    localparam int unsigned PROD_W = RUNS_W + SEED_W;

    logic [PROD_W-1:0] w_prod;
    logic [SEED_W-1:0] w_off;
    logic [SEED_W-1:0] w_sx;
    logic [SEED_W-1:0] w_sy;

    // Seed arithmetic wraps modulo 2^9.
    always_comb begin
        w_prod   = PROD_W'(i_run) * PROD_W'(SEED_STRIDE);
        w_off    = w_prod[SEED_W-1:0];
        w_sx     = i_seed_x + w_off;
        w_sy     = i_seed_y - w_off;
        o_seed_x = fix_seed(w_sx);
        o_seed_y = fix_seed(w_sy);
    end

endmodule

// File: rtl/bas_restart_ctrl.sv
// Multi-restart sequencer for one bas core: runs the core num_runs times with distinct
// seeds and keeps the global best (x, y, value).
// Optional watchdog on the RUN state enabled by defining BAS_CTRL_TIMEOUT_EN.
module bas_restart_ctrl
    import bas_pkg::*;
#(
    parameter int unsigned       RUNS_W         = 8,
    parameter logic [SEED_W-1:0] SEED_STRIDE    = 9'd37
`ifdef BAS_CTRL_TIMEOUT_EN
    ,
    parameter int unsigned       TIMEOUT_MARGIN = 16
`endif
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [RUNS_W-1:0]   num_runs,
    input  logic [ITER_W-1:0]   iterations,
    input  logic [SEED_W-1:0]   seed_x,
    input  logic [SEED_W-1:0]   seed_y,
    input  logic [Q88_W-1:0]    x0,
    input  logic [Q88_W-1:0]    y0,
    output logic                busy,
    output logic                done,
    output logic                best_valid,
    output logic [Q88_W-1:0]    best_x,
    output logic [Q88_W-1:0]    best_y,
    output logic [VALUE_W-1:0]  best_value,
    output logic [RUNS_W-1:0]   best_run,
    output logic                timeout_err,
    output logic                core_reset,
    output logic                core_load,
    output logic [SEED_W-1:0]   core_seed_x,
    output logic [SEED_W-1:0]   core_seed_y,
    output logic [ITER_W-1:0]   core_iterations,
    output logic [Q88_W-1:0]    core_x,
    output logic [Q88_W-1:0]    core_y,
    input  logic [Q88_W-1:0]    core_x_ext,
    input  logic [Q88_W-1:0]    core_y_ext,
    input  logic [VALUE_W-1:0]  core_value,
    input  logic                core_done
);

    state_e              r_state;
    state_e              w_state_d;

    logic [RUNS_W-1:0]   r_run;
    logic [RUNS_W-1:0]   r_num_runs;
    logic [ITER_W-1:0]   r_iterations;
    logic [SEED_W-1:0]   r_seed_x;
    logic [SEED_W-1:0]   r_seed_y;
    logic [Q88_W-1:0]    r_x0;
    logic [Q88_W-1:0]    r_y0;

    logic                r_best_valid;
    logic [Q88_W-1:0]    r_best_x;
    logic [Q88_W-1:0]    r_best_y;
    logic [VALUE_W-1:0]  r_best_value;
    logic [RUNS_W-1:0]   r_best_run;

    logic                w_latch;
    logic                w_better;
    logic                w_run_inc;
    logic                w_last;
    logic                w_tmo;

    bas_seed_gen #(
        .RUNS_W      (RUNS_W),
        .SEED_STRIDE (SEED_STRIDE)
    ) u_seed_gen (
        .i_run    (r_run),
        .i_seed_x (r_seed_x),
        .i_seed_y (r_seed_y),
        .o_seed_x (core_seed_x),
        .o_seed_y (core_seed_y)
    );

`ifdef BAS_CTRL_TIMEOUT_EN
    logic [ITER_W:0]     r_tcnt;
    logic [ITER_W:0]     w_tmo_limit;
    logic                r_timeout_err;

    // Last RUN cycle index before the watchdog fires (iterations + margin cycles in total).
    always_comb begin
        w_tmo_limit = {1'b0, r_iterations} + (ITER_W+1)'(TIMEOUT_MARGIN) - (ITER_W+1)'(1);
    end

    // Watchdog counter counts RUN cycles; sticky error cleared on new start.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_tcnt        <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_tcnt <= (r_state == StRun) ? r_tcnt + (ITER_W+1)'(1) : '0;
            if (w_latch) begin
                r_timeout_err <= 1'b0;
            end else if (w_tmo) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign timeout_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state logic and datapath enables.
    always_comb begin
        w_state_d = r_state;
        w_latch   = 1'b0;
        w_better  = 1'b0;
        w_run_inc = 1'b0;
        w_tmo     = 1'b0;
        w_last    = (r_run == r_num_runs - RUNS_W'(1));
        case (r_state)
            StIdle: begin
                // abort beats start when both arrive in IDLE
                if (start && !abort) begin
                    w_latch   = 1'b1;
                    w_state_d = (num_runs == '0) ? StFin : StCrst;
                end
            end
            StCrst:  w_state_d = StCload;
            StCload: w_state_d = StRun;
            StRun: begin
                if (core_done) begin
                    w_state_d = StCapt;
`ifdef BAS_CTRL_TIMEOUT_EN
                end else if (r_tcnt == w_tmo_limit) begin
                    w_tmo     = 1'b1;
                    w_state_d = StFin;
`endif
                end
            end
            StCapt: begin
                w_better = (core_value != CORE_SENTINEL) &&
                           ($signed(core_value) < $signed(r_best_value));
                if (w_last) begin
                    w_state_d = StFin;
                end else begin
                    w_run_inc = 1'b1;
                    w_state_d = StCrst;
                end
            end
            StFin:   w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
        // Abort drops everything; partial best results stay as they are.
        if (abort && (r_state != StIdle)) begin
            w_state_d = StIdle;
            w_better  = 1'b0;
            w_run_inc = 1'b0;
            w_tmo     = 1'b0;
        end
    end

    // Config latch, run index and global-best tracking.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_run        <= '0;
            r_num_runs   <= '0;
            r_iterations <= '0;
            r_seed_x     <= '0;
            r_seed_y     <= '0;
            r_x0         <= '0;
            r_y0         <= '0;
            r_best_valid <= 1'b0;
            r_best_x     <= '0;
            r_best_y     <= '0;
            r_best_value <= BEST_INIT;
            r_best_run   <= '0;
        end else begin
            if (w_latch) begin
                r_run        <= '0;
                r_num_runs   <= num_runs;
                r_iterations <= iterations;
                r_seed_x     <= seed_x;
                r_seed_y     <= seed_y;
                r_x0         <= x0;
                r_y0         <= y0;
                r_best_valid <= 1'b0;
                r_best_x     <= '0;
                r_best_y     <= '0;
                r_best_value <= BEST_INIT;
                r_best_run   <= '0;
            end
            // Strict compare: ties keep the earlier run.
            if (w_better) begin
                r_best_valid <= 1'b1;
                r_best_x     <= core_x_ext;
                r_best_y     <= core_y_ext;
                r_best_value <= core_value;
                r_best_run   <= r_run;
            end
            if (w_run_inc) begin
                r_run <= r_run + RUNS_W'(1);
            end
        end
    end

    // Decoded outputs.
    always_comb begin
        busy            = (r_state != StIdle) && (r_state != StFin);
        done            = (r_state == StFin);
        core_reset      = (r_state == StIdle) || (r_state == StCrst);
        core_load       = (r_state == StCload);
        core_iterations = r_iterations;
        core_x          = r_x0;
        core_y          = r_y0;
        best_valid      = r_best_valid;
        best_x          = r_best_x;
        best_y          = r_best_y;
        best_value      = r_best_value;
        best_run        = r_best_run;
    end

endmodule

// File: tb/tb_bas_restart_ctrl.sv
// Self-checking bench for bas_restart_ctrl with a behavioural core model and a result
// scoreboard.
`timescale 1ns/1ps
module tb_bas_restart_ctrl;
    import bas_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [7:0]  num_runs;
    logic [8:0]  iterations;
    logic [8:0]  seed_x;
    logic [8:0]  seed_y;
    logic [15:0] x0;
    logic [15:0] y0;
    logic        busy;
    logic        done;
    logic        best_valid;
    logic [15:0] best_x;
    logic [15:0] best_y;
    logic [39:0] best_value;
    logic [7:0]  best_run;
    logic        timeout_err;
    logic        core_reset;
    logic        core_load;
    logic [8:0]  core_seed_x;
    logic [8:0]  core_seed_y;
    logic [8:0]  core_iterations;
    logic [15:0] core_x;
    logic [15:0] core_y;
    logic [15:0] core_x_ext;
    logic [15:0] core_y_ext;
    logic [39:0] core_value;
    logic        core_done;

    always #5 clock = ~clock;

    bas_restart_ctrl dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .abort           (abort),
        .num_runs        (num_runs),
        .iterations      (iterations),
        .seed_x          (seed_x),
        .seed_y          (seed_y),
        .x0              (x0),
        .y0              (y0),
        .busy            (busy),
        .done            (done),
        .best_valid      (best_valid),
        .best_x          (best_x),
        .best_y          (best_y),
        .best_value      (best_value),
        .best_run        (best_run),
        .timeout_err     (timeout_err),
        .core_reset      (core_reset),
        .core_load       (core_load),
        .core_seed_x     (core_seed_x),
        .core_seed_y     (core_seed_y),
        .core_iterations (core_iterations),
        .core_x          (core_x),
        .core_y          (core_y),
        .core_x_ext      (core_x_ext),
        .core_y_ext      (core_y_ext),
        .core_value      (core_value),
        .core_done       (core_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Bench-side copy of the active configuration (for the models).
    logic [8:0]  cur_sx = '0;
    logic [8:0]  cur_sy = '0;
    logic [15:0] cur_x0 = '0;
    logic [15:0] cur_y0 = '0;
    logic [7:0]  run_base = '0;
    logic [39:0] vals [4];

    function automatic logic [8:0] mdl_seed(input logic [8:0] base, input int r, input bit add);
        logic [8:0] off;
        logic [8:0] s;
        off = 9'((r * 37) % 512);
        s   = add ? base + off : base - off;
        return (s == 9'd0) ? 9'd1 : s;
    endfunction

    // Core model: done after iterations+1 RUN cycles, value from table indexed by run.
    logic       m_running = 1'b0;
    logic [8:0] m_cnt = '0;
    logic [7:0] m_load_cnt = '0;
    logic [7:0] m_idx = '0;

    always @(posedge clock) begin
        if (core_reset) begin
            m_running <= 1'b0;
            m_cnt     <= '0;
        end else if (core_load) begin
            m_running  <= 1'b1;
            m_cnt      <= '0;
            m_idx      <= m_load_cnt - run_base;
            m_load_cnt <= m_load_cnt + 8'd1;
        end else if (m_running && !core_done) begin
            m_cnt <= m_cnt + 9'd1;
        end
    end

    assign core_done  = m_running && (m_cnt == core_iterations);
    assign core_value = (core_iterations == 9'd0) ? CORE_SENTINEL : vals[m_idx[1:0]];
    assign core_x_ext = core_x + {7'b0, core_seed_x};
    assign core_y_ext = core_y - {7'b0, core_seed_y};

    // Seeds and start position presented to the core on every load.
    always @(negedge clock) begin : seed_chk
        int r;
        if (core_load) begin
            r = int'(m_load_cnt - run_base);
            check("core_seed_x", core_seed_x, mdl_seed(cur_sx, r, 1'b1));
            check("core_seed_y", core_seed_y, mdl_seed(cur_sy, r, 1'b0));
            check("core_x", core_x, cur_x0);
        end
    end

    typedef struct {
        logic        valid;
        logic [39:0] value;
        logic [7:0]  run;
        logic [15:0] x;
        logic [15:0] y;
        int          lat;
    } exp_t;

    exp_t sbq[$];

    function automatic exp_t model(input int nr, input int it);
        exp_t        e;
        logic [39:0] v;
        e.valid = 1'b0;
        e.value = BEST_INIT;
        e.run   = '0;
        e.x     = '0;
        e.y     = '0;
        for (int r = 0; r < nr; r++) begin
            v = (it == 0) ? CORE_SENTINEL : vals[r % 4];
            if (v != CORE_SENTINEL && $signed(v) < $signed(e.value)) begin
                e.valid = 1'b1;
                e.value = v;
                e.run   = 8'(r);
                e.x     = cur_x0 + {7'b0, mdl_seed(cur_sx, r, 1'b1)};
                e.y     = cur_y0 - {7'b0, mdl_seed(cur_sy, r, 1'b0)};
            end
        end
        e.lat = (nr == 0) ? 1 : nr * (it + 4) + 1;
        return e;
    endfunction

    task automatic kick(input int nr, input int it, input logic [8:0] sx, input logic [8:0] sy,
                        input logic [15:0] px, input logic [15:0] py);
        @(negedge clock);
        cur_sx     = sx;
        cur_sy     = sy;
        cur_x0     = px;
        cur_y0     = py;
        run_base   = m_load_cnt;
        num_runs   = 8'(nr);
        iterations = 9'(it);
        seed_x     = sx;
        seed_y     = sy;
        x0         = px;
        y0         = py;
        start      = 1'b1;
        @(negedge clock);
        start      = 1'b0;
    endtask

    // Full sequence: push the expected result, wait for done, pop and compare.
    task automatic run_seq(input int nr, input int it, input logic [8:0] sx, input logic [8:0] sy,
                           input logic [15:0] px, input logic [15:0] py, input bit poke);
        int   n;
        exp_t e;
        cur_sx = sx;
        cur_sy = sy;
        cur_x0 = px;
        cur_y0 = py;
        sbq.push_back(model(nr, it));
        kick(nr, it, sx, sy, px, py);
        n = 1;
        if (nr != 0) check("busy_early", busy, 1);
        while (n < 3000 && !done) begin
            // a start while busy (with different config) must be ignored
            start = poke && (n == 5);
            if (start) begin
                num_runs = 8'd1;
                seed_x   = 9'h0AA;
            end
            @(negedge clock);
            n++;
        end
        start = 1'b0;
        check("done_seen", done, 1);
        e = sbq.pop_front();
        check("latency", 64'(n), 64'(e.lat));
        check("busy_at_done", busy, 0);
        check("best_valid", best_valid, e.valid);
        check("best_value", best_value, e.value);
        check("best_run", best_run, e.run);
        check("best_x", best_x, e.x);
        check("best_y", best_y, e.y);
        @(negedge clock);
        check("done_one_cycle", done, 0);
    endtask

    initial begin : main
        int n;
        int dones;
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        num_runs = '0;
        iterations = '0;
        seed_x = '0;
        seed_y = '0;
        x0 = '0;
        y0 = '0;
        for (int i = 0; i < 4; i++) vals[i] = 40'd0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_best_valid", best_valid, 0);
        check("rst_best_value", best_value, BEST_INIT);
        check("rst_best_run", best_run, 0);
        check("rst_core_reset", core_reset, 1);
        check("rst_core_load", core_load, 0);
        check("rst_timeout_err", timeout_err, 0);

        // Single run: result is whatever the core returned.
        vals[0] = 40'd500;
        run_seq(1, 10, 9'h01A, 9'h02B, 16'h0100, 16'h0200, 1'b0);

        // Four runs with a tie: earlier run wins; a start mid-sequence is ignored.
        vals[0] = 40'd500;
        vals[1] = 40'd300;
        vals[2] = 40'd300;
        vals[3] = 40'd900;
        run_seq(4, 3, 9'h1F0, 9'h010, 16'hFF00, 16'h0080, 1'b1);

        // Negative values and seed zero-substitution on both x (run 0) and y (run 1).
        vals[0] = -40'sd5;
        vals[1] = 40'd7;
        vals[2] = -40'sd20;
        vals[3] = 40'd100;
        run_seq(4, 2, 9'h000, 9'd37, 16'h1234, 16'h8000, 1'b0);

        // Zero iterations: every run yields the sentinel.
        run_seq(2, 0, 9'h055, 9'h0AA, 16'h0001, 16'h0002, 1'b0);

        // A valid result first, then num_runs=0 must clear it.
        vals[0] = 40'd42;
        run_seq(1, 1, 9'h003, 9'h004, 16'h0010, 16'h0020, 1'b0);
        run_seq(0, 5, 9'h003, 9'h004, 16'h0010, 16'h0020, 1'b0);

        // Abort during run 2 of 4: best reflects runs 0 and 1.
        vals[0] = 40'd500;
        vals[1] = 40'd300;
        vals[2] = 40'd200;
        vals[3] = 40'd100;
        kick(4, 10, 9'h011, 9'h022, 16'h0300, 16'h0400);
        n = 0;
        while ((m_load_cnt - run_base) != 8'd3 && n < 500) begin
            @(negedge clock);
            n++;
        end
        check("reach_run2", 64'(m_load_cnt - run_base), 3);
        repeat (3) @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_core_reset", core_reset, 1);
        dones = 0;
        for (int i = 0; i < 60; i++) begin
            if (done) dones++;
            @(negedge clock);
        end
        check("abort_no_done", 64'(dones), 0);
        check("abort_best_valid", best_valid, 1);
        check("abort_best_value", best_value, 40'd300);
        check("abort_best_run", best_run, 1);
        check("abort_best_x", best_x, 16'h0300 + {7'b0, mdl_seed(9'h011, 1, 1'b1)});

        // abort and start together in IDLE: abort wins.
        abort = 1'b1;
        start = 1'b1;
        num_runs = 8'd2;
        @(negedge clock);
        abort = 1'b0;
        start = 1'b0;
        check("abort_start_busy", busy, 0);
        check("abort_start_best", best_value, 40'd300);

        // Reset mid-run restores everything.
        kick(2, 20, 9'h077, 9'h066, 16'h0001, 16'h0001);
        repeat (10) @(negedge clock);
        check("pre_reset_busy", busy, 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_best_valid", best_valid, 0);
        check("mid_rst_best_value", best_value, BEST_INIT);
        check("mid_rst_core_reset", core_reset, 1);
        check("timeout_err_off", timeout_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
